// File: rtl/aplic_msi_sched.sv
// MSI delivery scheduler for one APLIC domain: picks a genmsi request or a pending source,
// clears its pending bit and issues one MSI write. Define APLIC_MSI_SCHED_RR_EN for round-robin.
module aplic_msi_sched #(
    parameter int NR_SRC   = 32,
    parameter int NR_SRC_W = $clog2(NR_SRC),
    parameter int PPN_W    = 44
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_domain_ie,
    input  logic [NR_SRC-1:0]   i_pend,
    input  logic [NR_SRC-1:0]   i_en,
    output logic [NR_SRC_W-1:0] o_tgt_idx,
    input  logic [31:0]         i_tgt,
    output logic                o_clrip_valid,
    output logic [NR_SRC_W-1:0] o_clrip_idx,
    input  logic                i_genmsi_valid,
    input  logic [13:0]         i_genmsi_hi,
    input  logic [10:0]         i_genmsi_eiid,
    output logic                o_genmsi_done,
    input  logic [PPN_W-1:0]    i_msiaddr_ppn,
    input  logic [2:0]          i_lhxs,
    output logic                o_msi_valid,
    input  logic                i_msi_ready,
    output logic [63:0]         o_msi_addr,
    output logic [31:0]         o_msi_data,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e              state_q;
    logic                is_gen_q;
    logic                msi_valid_q;
    logic [63:0]         msi_addr_q;
    logic [31:0]         msi_data_q;
    logic                clrip_valid_q;
    logic [NR_SRC_W-1:0] clrip_idx_q;
    logic [NR_SRC_W-1:0] tgt_idx_q;
    logic                busy_q;

    logic [NR_SRC-1:0]   req_s;
    logic                win_found_s;
    logic [NR_SRC_W-1:0] win_idx_s;
    logic [NR_SRC_W-1:0] cand_s;
    logic [63:0]         sel_addr_s;
    logic [63:0]         gen_addr_s;
    logic                unused_s;

    // MSI page number merges the hart and guest index into the base PPN; overflow is truncated.
    function automatic logic [63:0] msi_addr(input logic [PPN_W-1:0] base,
                                             input logic [13:0]      hi,
                                             input logic [5:0]       gi,
                                             input logic [2:0]       lhxs);
        logic [PPN_W-1:0] ppn;
        ppn = base | (PPN_W'(hi) << lhxs) | PPN_W'(gi);
        return 64'({ppn, 12'h000});
    endfunction

`ifdef APLIC_MSI_SCHED_RR_EN
    logic [NR_SRC_W-1:0] rr_ptr_q;

    // Round-robin winner: first requester at or after the pointer, wrapping past source 0.
    always_comb begin
        req_s       = i_pend & i_en;
        req_s[0]    = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = NR_SRC - 2; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr_q) + i;
            if (j >= NR_SRC) begin
                j = j - (NR_SRC - 1);
            end else begin
                j = j;
            end
            cand_s = NR_SRC_W'(j);
            if (req_s[cand_s]) begin
                win_idx_s = cand_s;
            end else begin
                win_idx_s = win_idx_s;
            end
        end
        win_found_s = |req_s;
    end
`else
    // Fixed priority winner: lowest requesting index.
    always_comb begin
        req_s       = i_pend & i_en;
        req_s[0]    = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = NR_SRC - 1; i >= 1; i--) begin
            cand_s = NR_SRC_W'(i);
            if (req_s[cand_s]) begin
                win_idx_s = cand_s;
            end else begin
                win_idx_s = win_idx_s;
            end
        end
        win_found_s = |req_s;
    end
`endif

    // Candidate addresses for the two request kinds.
    always_comb begin
        sel_addr_s = msi_addr(i_msiaddr_ppn, i_tgt[31:18], i_tgt[17:12], i_lhxs);
        gen_addr_s = msi_addr(i_msiaddr_ppn, i_genmsi_hi, 6'd0, i_lhxs);
    end

    assign unused_s = ^{i_tgt[11], i_pend[0], i_en[0]};

    // Scheduler FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            is_gen_q      <= 1'b0;
            msi_valid_q   <= 1'b0;
            msi_addr_q    <= 64'd0;
            msi_data_q    <= 32'd0;
            clrip_valid_q <= 1'b0;
            clrip_idx_q   <= '0;
            tgt_idx_q     <= '0;
            busy_q        <= 1'b0;
`ifdef APLIC_MSI_SCHED_RR_EN
            rr_ptr_q      <= NR_SRC_W'(1);
`endif
        end else begin
            clrip_valid_q <= 1'b0;
            clrip_idx_q   <= '0;
            tgt_idx_q     <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (i_genmsi_valid) begin
                        is_gen_q    <= 1'b1;
                        msi_addr_q  <= gen_addr_s;
                        msi_data_q  <= {21'd0, i_genmsi_eiid};
                        msi_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SEND;
                    end else if (i_domain_ie && win_found_s) begin
                        is_gen_q      <= 1'b0;
                        tgt_idx_q     <= win_idx_s;
                        clrip_valid_q <= 1'b1;
                        clrip_idx_q   <= win_idx_s;
                        busy_q        <= 1'b1;
                        state_q       <= ST_SEL;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEL: begin
`ifdef APLIC_MSI_SCHED_RR_EN
                    rr_ptr_q <= (tgt_idx_q == NR_SRC_W'(NR_SRC - 1)) ? NR_SRC_W'(1)
                                                                      : tgt_idx_q + NR_SRC_W'(1);
`endif
                    // A zero EIID means the target is unconfigured: the interrupt is dropped.
                    if (i_tgt[10:0] == 11'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        msi_addr_q  <= sel_addr_s;
                        msi_data_q  <= {21'd0, i_tgt[10:0]};
                        msi_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_msi_ready) begin
                        msi_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_SEND;
                    end
                end
                default: begin
                    msi_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tgt_idx     = tgt_idx_q;
    assign o_clrip_valid = clrip_valid_q;
    assign o_clrip_idx   = clrip_idx_q;
    // Done must coincide with the handshake so genmsi.busy drops before the next IDLE look.
    assign o_genmsi_done = msi_valid_q & is_gen_q & i_msi_ready;
    assign o_msi_valid   = msi_valid_q;
    assign o_msi_addr    = msi_addr_q;
    assign o_msi_data    = msi_data_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_aplic_msi_sched.sv
// Randomized bench for aplic_msi_sched against a transaction-level reference model.
module tb_aplic_msi_sched;
    localparam int NR  = 32;
    localparam int NW  = 5;
    localparam int PW  = 44;
    localparam int P_IDLE = 0;
    localparam int P_SEL  = 1;
    localparam int P_SEND = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ie;
    logic [NR-1:0] pend;
    logic [NR-1:0] en;
    logic [NW-1:0] tgt_idx;
    logic [31:0]   tgt;
    logic          clrip_v;
    logic [NW-1:0] clrip_idx;
    logic          genv;
    logic [13:0]   ghi;
    logic [10:0]   geiid;
    logic          gdone;
    logic [PW-1:0] ppn;
    logic [2:0]    lhxs;
    logic          mvalid;
    logic          mready;
    logic [63:0]   maddr;
    logic [31:0]   mdata;
    logic          busy;

    logic [31:0]   tgt_tab [NR];
    int            n_tests = 0;
    int            n_fail  = 0;

    int            m_phase;
    int            m_k;
    int            m_ptr;
    bit            m_gen;
    logic [63:0]   m_addr;
    logic [31:0]   m_data;

    always #5 clk = ~clk;
    assign tgt = tgt_tab[tgt_idx];

    aplic_msi_sched dut (
        .i_clk(clk), .i_rst(rst), .i_domain_ie(ie), .i_pend(pend), .i_en(en),
        .o_tgt_idx(tgt_idx), .i_tgt(tgt), .o_clrip_valid(clrip_v), .o_clrip_idx(clrip_idx),
        .i_genmsi_valid(genv), .i_genmsi_hi(ghi), .i_genmsi_eiid(geiid), .o_genmsi_done(gdone),
        .i_msiaddr_ppn(ppn), .i_lhxs(lhxs), .o_msi_valid(mvalid), .i_msi_ready(mready),
        .o_msi_addr(maddr), .o_msi_data(mdata), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_addr(input logic [PW-1:0] base, input logic [13:0] hi,
                                             input logic [5:0] gi, input logic [2:0] sh);
        logic [63:0] p;
        p = {20'd0, base} | ({50'd0, hi} << sh) | {58'd0, gi};
        p = p & 64'h0000_0FFF_FFFF_FFFF;
        return p << 12;
    endfunction

    // Source the spec would pick now, or 0 if none.
    function automatic int pick();
`ifdef APLIC_MSI_SCHED_RR_EN
        for (int off = 0; off < NR - 1; off++) begin
            int j;
            j = ((m_ptr - 1 + off) % (NR - 1)) + 1;
            if (pend[j] && en[j]) return j;
        end
`else
        for (int j = 1; j < NR; j++) begin
            if (pend[j] && en[j]) return j;
        end
`endif
        return 0;
    endfunction

    task automatic model_step();
        logic [31:0] t;
        int w;
        if (rst) begin
            m_phase = P_IDLE;
            m_ptr   = 1;
            m_gen   = 1'b0;
        end else if (m_phase == P_IDLE) begin
            w = pick();
            if (genv) begin
                m_gen   = 1'b1;
                m_addr  = ref_addr(ppn, ghi, 6'd0, lhxs);
                m_data  = {21'd0, geiid};
                m_phase = P_SEND;
            end else if (ie && w != 0) begin
                m_gen   = 1'b0;
                m_k     = w;
                m_phase = P_SEL;
            end
        end else if (m_phase == P_SEL) begin
            t     = tgt_tab[m_k];
            m_ptr = (m_k % (NR - 1)) + 1;
            if (t[10:0] == 11'd0) begin
                m_phase = P_IDLE;
            end else begin
                m_addr  = ref_addr(ppn, t[31:18], t[17:12], lhxs);
                m_data  = {21'd0, t[10:0]};
                m_phase = P_SEND;
            end
        end else if (mready) begin
            m_phase = P_IDLE;
        end
    endtask

    // One clock: check the combinational done, advance model and DUT, react like the APLIC, check.
    task automatic cycle();
        bit clr_c;
        bit done_c;
        int clr_i;
        #1;
        if (!rst) check("genmsi_done", gdone, (m_phase == P_SEND) && m_gen && mready);
        clr_c  = (clrip_v === 1'b1);
        clr_i  = int'(clrip_idx);
        done_c = (gdone === 1'b1);
        @(posedge clk);
        model_step();
        #1;
        if (clr_c) pend[clr_i] = 1'b0;
        if (done_c) genv = 1'b0;
        check("busy", busy, m_phase != P_IDLE);
        check("msi_valid", mvalid, m_phase == P_SEND);
        check("clrip_valid", clrip_v, m_phase == P_SEL);
        check("clrip_idx", clrip_idx, (m_phase == P_SEL) ? m_k : 0);
        check("tgt_idx", tgt_idx, (m_phase == P_SEL) ? m_k : 0);
        if (m_phase == P_SEND) begin
            check("msi_addr", maddr, m_addr);
            check("msi_data", mdata, m_data);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; ie = 1'b1; pend = '0; en = '0; genv = 1'b0; ghi = '0; geiid = '0;
        ppn = 44'h80000; lhxs = 3'd0; mready = 1'b1;
        m_phase = P_IDLE; m_k = 0; m_ptr = 1; m_gen = 1'b0; m_addr = '0; m_data = '0;
        for (int i = 0; i < NR; i++) tgt_tab[i] = $urandom | 32'h0000_0001;
        tgt_tab[3] = 32'h0005_1800;
        tgt_tab[5] = {14'd3, 6'd0, 1'b0, 11'h2A};
        repeat (3) cycle();
        check("rst_addr", maddr, 64'd0);
        check("rst_data", mdata, 32'd0);
        rst = 1'b0;
        cycle();

        // Single source: fixed latency and known address.
        pend = 32'h20; en = 32'h20;
        n = 0;
        while (mvalid !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        check("t1_latency", n, 2);
        check("t1_addr", maddr, 64'h8000_3000);
        check("t1_data", mdata, 32'h2A);
        repeat (3) cycle();

        // Unconfigured target drops the interrupt; ie=0 blocks selection.
        pend = 32'h8; en = 32'h8;
        repeat (4) cycle();
        check("t5_pend_cleared", pend[3], 1'b0);
        ie = 1'b0; pend = 32'h80; en = 32'hFFFF_FFFF;
        repeat (4) cycle();
        check("t5_ie_blocks", pend[7], 1'b1);
        ie = 1'b1;
        repeat (4) cycle();

        // genmsi raised together with a source, then back-pressure.
        genv = 1'b1; ghi = 14'd1; geiid = 11'd7; pend = 32'h10; mready = 1'b0;
        repeat (6) cycle();
        mready = 1'b1;
        repeat (6) cycle();

        // Reset while an MSI is outstanding.
        mready = 1'b0; tgt_tab[9] = 32'h0000_0123; pend = 32'h200;
        n = 0;
        while (mvalid !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        check("t6_reach_send", mvalid, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_valid_dropped", mvalid, 1'b0);
        mready = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            rst    = ($urandom_range(0, 299) == 0);
            ie     = ($urandom_range(0, 9) != 0);
            mready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) pend[$urandom_range(1, NR - 1)] = 1'b1;
            if ($urandom_range(0, 29) == 0) en = $urandom;
            if (!genv && $urandom_range(0, 15) == 0) begin
                genv  = 1'b1;
                ghi   = 14'($urandom);
                geiid = 11'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                ppn  = PW'({$urandom, $urandom});
                lhxs = 3'($urandom);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
